mem_arbiter: RTL and testbench
==============================

Name: mem_arbiter

Overview:
Arbitrates a single external memory port between the instruction-fetch requester and the data requester (the data-cache controller's read fill and write-through path).
- Serializes requests: one outstanding memory transaction at a time.
- Speaks the ready/done handshake of the memory system.
- Returns a one-cycle acknowledge to the granted requester.
- Sits between the core/cache controllers and the memory model.

Parameters:
TIMEOUT, 255, cycles a transaction may wait for mem_read_ready or mem_write_done before abort (1..65535)

Ports:
clk  in  1  clock, all state updates on rising edge
reset  in  1  synchronous, active-high reset
i_req  in  1  instruction read request; held until i_ack
i_addr  in  32  instruction address; stable while i_req
i_rdata  out  32  instruction read data; valid when i_ack
i_ack  out  1  one-cycle completion pulse to fetch side
d_read  in  1  data read request; held until d_ack
d_write  in  1  data write request; held until d_ack
d_addr  in  32  data address; stable while requesting
d_wdata  in  32  write data; stable while d_write
d_rdata  out  32  data read result; valid when d_ack
d_ack  out  1  one-cycle completion pulse to data side
mem_addr  out  32  memory address (registered)
mem_wdata  out  32  memory write data (registered)
mem_read  out  1  memory read strobe
mem_write  out  1  memory write strobe
mem_read_ready  in  1  memory read data valid on mem_rdata
mem_rdata  in  32  memory read data
mem_write_done  in  1  memory write accepted
bus_err  out  1  one-cycle pulse with ack when the transaction timed out

Behaviour:
- States: IDLE, IRD, DRD, DWR, RESP.
- Reset:
  - state=IDLE, last_grant=I, timeout counter=0.
  - All outputs 0: mem_addr, mem_wdata, i_rdata, d_rdata = 32'h0.
  - Reset mid-transaction aborts with no ack; mem_read/mem_write low after the edge.
- Data request precedence: d_write beats d_read if both are asserted.
- IDLE arbitration, sampled each cycle:
  - Only one side requesting: grant it.
  - Both requesting: grant the side not equal to last_grant (round-robin).
  - last_grant resets to I, so data wins the first tie.
- On grant:
  - Latch the granted address (and d_wdata for writes) into mem_addr/mem_wdata.
  - Set last_grant, clear the counter.
  - Go to IRD, DRD or DWR.
- IRD/DRD:
  - mem_read=1, mem_write=0.
  - Counter increments each cycle.
  - mem_read_ready=1: latch mem_rdata into i_rdata (IRD) or d_rdata (DRD), go to RESP.
- DWR:
  - mem_write=1, mem_read=0.
  - mem_write_done=1: go to RESP.
- Timeout:
  - Counter reaches TIMEOUT-1 with no ready/done: go to RESP with err flag set; read data register loaded with 32'h0.
  - Ready/done in the same cycle as timeout wins; no error.
- RESP:
  - mem_read=mem_write=0.
  - Exactly one of i_ack/d_ack=1 for one cycle, matching the grant.
  - bus_err=1 this cycle only if the transaction timed out.
  - Next state IDLE; a new grant is possible in the following cycle.
- Latency:
  - Request seen in IDLE at cycle N, ready at N+1 gives ack at N+2.
  - Back-to-back transactions are spaced at least 3 cycles.
- Read data registers hold their value until the next completion to the same side.
- Ignored inputs:
  - mem_read_ready/mem_write_done in IDLE or RESP.
  - mem_read_ready during DWR; mem_write_done during IRD/DRD.
- Requester drops its request mid-transaction: the transaction still completes and ack still pulses.
- mem_addr/mem_wdata are stable for the entire IRD/DRD/DWR dwell.

Test Plan:
- i_req, i_addr=32'h0000_0040; mem_read_ready one cycle later with mem_rdata=32'h1234_5678 -> mem_read high 1 cycle, mem_addr=0x40; i_ack at request+2 with i_rdata=0x12345678; d_ack stays 0.
- i_req and d_read asserted together after reset -> data granted first (mem_addr=d_addr), then instruction; third tie with both held grants data again (alternation).
- d_write, d_addr=32'h100, d_wdata=32'hCAFE_F00D; mem_write_done after 4 cycles -> mem_write high exactly 4 cycles with stable addr/data; d_ack 1 cycle; bus_err=0.
- TIMEOUT=8, d_read, memory never ready -> mem_read high 8 cycles; d_ack and bus_err pulse together; d_rdata=0; next request serviced normally.
- Reset asserted in DRD while mem_read=1 -> next cycle mem_read=0, no ack, state IDLE; a later tie grants data first.
- d_read and d_write both asserted -> DWR performed (mem_write=1, mem_read=0); ready/done asserted spuriously in IDLE -> no ack.

Source files
------------

// File: rtl/mem_arbiter.sv
// mem_arbiter
//   Shares one external memory port between the instruction-fetch requester
//   and the data requester (read fill / write-through). Only one memory
//   transaction is in flight at a time. Each transaction ends with a
//   one-cycle acknowledge to the side that was granted.
//
// Ports
//   clk, reset        : clock and synchronous active-high reset
//   i_req/i_addr      : instruction read request and address (held until i_ack)
//   i_rdata/i_ack     : instruction read data and completion pulse
//   d_read/d_write    : data read / write requests (held until d_ack)
//   d_addr/d_wdata    : data address and write data
//   d_rdata/d_ack     : data read result and completion pulse
//   mem_addr/mem_wdata: registered memory address and write data
//   mem_read/mem_write: memory strobes, high for the whole access dwell
//   mem_read_ready    : memory read data valid on mem_rdata
//   mem_write_done    : memory accepted the write
//   bus_err           : pulses together with the ack when the access timed out
module mem_arbiter #(
  parameter int TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_req,
  input  logic [31:0] i_addr,
  output logic [31:0] i_rdata,
  output logic        i_ack,
  input  logic        d_read,
  input  logic        d_write,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic [31:0] d_rdata,
  output logic        d_ack,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        mem_read,
  output logic        mem_write,
  input  logic        mem_read_ready,
  input  logic [31:0] mem_rdata,
  input  logic        mem_write_done,
  output logic        bus_err
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    IRD  = 3'd1,
    DRD  = 3'd2,
    DWR  = 3'd3,
    RESP = 3'd4
  } state_t;

  // Last value the dwell counter may reach before the access is abandoned.
  localparam logic [15:0] COUNT_LAST = 16'(TIMEOUT - 1);

  state_t      state_reg, state_next;
  // 1 = data side owns the current/most recent grant, 0 = instruction side.
  // It doubles as the round-robin history and as the ack selector in RESP.
  logic        last_d_reg, last_d_next;
  logic [15:0] count_reg, count_next;
  logic        err_reg, err_next;
  logic [31:0] mem_addr_reg, mem_addr_next;
  logic [31:0] mem_wdata_reg, mem_wdata_next;
  logic [31:0] i_rdata_reg, i_rdata_next;
  logic [31:0] d_rdata_reg, d_rdata_next;

  logic d_req;
  logic grant_d;
  logic timed_out;

  assign d_req     = d_read | d_write;
  // Data wins when it is alone, or on a tie when instruction had the last grant.
  assign grant_d   = d_req && (!i_req || !last_d_reg);
  assign timed_out = (count_reg == COUNT_LAST);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg     <= IDLE;
      last_d_reg    <= 1'b0;
      count_reg     <= 16'd0;
      err_reg       <= 1'b0;
      mem_addr_reg  <= 32'h0;
      mem_wdata_reg <= 32'h0;
      i_rdata_reg   <= 32'h0;
      d_rdata_reg   <= 32'h0;
    end else begin
      state_reg     <= state_next;
      last_d_reg    <= last_d_next;
      count_reg     <= count_next;
      err_reg       <= err_next;
      mem_addr_reg  <= mem_addr_next;
      mem_wdata_reg <= mem_wdata_next;
      i_rdata_reg   <= i_rdata_next;
      d_rdata_reg   <= d_rdata_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    last_d_next    = last_d_reg;
    count_next     = count_reg;
    err_next       = err_reg;
    mem_addr_next  = mem_addr_reg;
    mem_wdata_next = mem_wdata_reg;
    i_rdata_next   = i_rdata_reg;
    d_rdata_next   = d_rdata_reg;

    case (state_reg)
      IDLE: begin
        err_next = 1'b0;
        if (grant_d) begin
          last_d_next   = 1'b1;
          count_next    = 16'd0;
          mem_addr_next = d_addr;
          // A write takes precedence over a simultaneous read.
          if (d_write) begin
            mem_wdata_next = d_wdata;
            state_next     = DWR;
          end else begin
            state_next = DRD;
          end
        end else if (i_req) begin
          last_d_next   = 1'b0;
          count_next    = 16'd0;
          mem_addr_next = i_addr;
          state_next    = IRD;
        end
      end

      IRD, DRD: begin
        // A ready arriving in the timeout cycle still completes cleanly.
        if (mem_read_ready) begin
          if (state_reg == IRD) i_rdata_next = mem_rdata;
          else                  d_rdata_next = mem_rdata;
          state_next = RESP;
        end else if (timed_out) begin
          if (state_reg == IRD) i_rdata_next = 32'h0;
          else                  d_rdata_next = 32'h0;
          err_next   = 1'b1;
          state_next = RESP;
        end else begin
          count_next = count_reg + 16'd1;
        end
      end

      DWR: begin
        if (mem_write_done) begin
          state_next = RESP;
        end else if (timed_out) begin
          err_next   = 1'b1;
          state_next = RESP;
        end else begin
          count_next = count_reg + 16'd1;
        end
      end

      RESP: begin
        state_next = IDLE;
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

  assign mem_addr  = mem_addr_reg;
  assign mem_wdata = mem_wdata_reg;
  assign i_rdata   = i_rdata_reg;
  assign d_rdata   = d_rdata_reg;
  assign mem_read  = (state_reg == IRD) || (state_reg == DRD);
  assign mem_write = (state_reg == DWR);
  assign i_ack     = (state_reg == RESP) && !last_d_reg;
  assign d_ack     = (state_reg == RESP) && last_d_reg;
  assign bus_err   = (state_reg == RESP) && err_reg;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter
//   Directed bench for mem_arbiter. Stimulus tasks play the requester and
//   memory roles and push the expected acknowledge of each transaction into
//   a queue; a monitor pops and compares whenever an ack appears.
module tb_mem_arbiter;

  localparam int TIMEOUT = 8;

  logic        clk;
  logic        reset;
  logic        i_req;
  logic [31:0] i_addr;
  logic [31:0] i_rdata;
  logic        i_ack;
  logic        d_read;
  logic        d_write;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic [31:0] d_rdata;
  logic        d_ack;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_read;
  logic        mem_write;
  logic        mem_read_ready;
  logic [31:0] mem_rdata;
  logic        mem_write_done;
  logic        bus_err;

  mem_arbiter #(.TIMEOUT(TIMEOUT)) dut (
    .clk            (clk),
    .reset          (reset),
    .i_req          (i_req),
    .i_addr         (i_addr),
    .i_rdata        (i_rdata),
    .i_ack          (i_ack),
    .d_read         (d_read),
    .d_write        (d_write),
    .d_addr         (d_addr),
    .d_wdata        (d_wdata),
    .d_rdata        (d_rdata),
    .d_ack          (d_ack),
    .mem_addr       (mem_addr),
    .mem_wdata      (mem_wdata),
    .mem_read       (mem_read),
    .mem_write      (mem_write),
    .mem_read_ready (mem_read_ready),
    .mem_rdata      (mem_rdata),
    .mem_write_done (mem_write_done),
    .bus_err        (bus_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit          side_d;
    logic [31:0] data;
    bit          check_data;
    bit          err;
  } exp_t;

  exp_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %h required %h", name, act, req);
    end
  endtask

  // Monitor: one line per acknowledged transaction.
  always @(negedge clk) begin
    if (i_ack === 1'b1 || d_ack === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_ack: got i_ack=%b d_ack=%b required none", i_ack, d_ack);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("ack_pair", {30'h0, d_ack, i_ack}, e.side_d ? 32'h2 : 32'h1);
        check("resp_err", {31'h0, bus_err}, {31'h0, e.err});
        if (e.check_data)
          check("resp_data", e.side_d ? d_rdata : i_rdata, e.data);
        $display("txn side=%s data=%h err=%b", e.side_d ? "D" : "I",
                 e.side_d ? d_rdata : i_rdata, bus_err);
      end
    end
  end

  // kind: 0 = instruction read, 1 = data read, 2 = data write.
  // lat : dwell cycle in which ready/done is given; 0 = never (timeout).
  // Called #1 after an edge with the request already driven and the DUT in
  // IDLE; returns #1 after the edge leaving RESP with the served request dropped.
  task automatic serve(input int kind, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [31:0] rdata, input int lat);
    exp_t e;
    int   n;
    bit   to;
    to           = (lat == 0);
    e.side_d     = (kind != 0);
    e.data       = to ? 32'h0 : rdata;
    e.check_data = (kind != 2);
    e.err        = to;
    exp_q.push_back(e);
    @(posedge clk); #1;
    n = 0;
    while ((mem_read || mem_write) && n < 50) begin
      check("strobe_rd", {31'h0, mem_read}, (kind != 2) ? 32'h1 : 32'h0);
      check("strobe_wr", {31'h0, mem_write}, (kind == 2) ? 32'h1 : 32'h0);
      check("mem_addr", mem_addr, addr);
      if (kind == 2) check("mem_wdata", mem_wdata, wdata);
      n++;
      if (n == lat) begin
        if (kind == 2) mem_write_done = 1'b1;
        else begin
          mem_read_ready = 1'b1;
          mem_rdata      = rdata;
        end
      end else begin
        // The handshake of the other direction must be ignored.
        if (kind == 2) mem_read_ready = 1'b1;
        else           mem_write_done = 1'b1;
        mem_rdata = 32'hDEAD_BEEF;
      end
      @(posedge clk); #1;
      mem_read_ready = 1'b0;
      mem_write_done = 1'b0;
    end
    check("dwell", n, to ? TIMEOUT : lat);
    check("ack_now", {30'h0, d_ack, i_ack}, (kind == 0) ? 32'h1 : 32'h2);
    check("err_now", {31'h0, bus_err}, {31'h0, to});
    if (kind == 0) i_req = 1'b0;
    else begin
      d_read  = 1'b0;
      d_write = 1'b0;
    end
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; i_req = 1'b0; i_addr = 32'h0;
    d_read = 1'b0; d_write = 1'b0; d_addr = 32'h0; d_wdata = 32'h0;
    mem_read_ready = 1'b0; mem_rdata = 32'h0; mem_write_done = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    // Reset state
    check("rst_mem_addr", mem_addr, 32'h0);
    check("rst_mem_wdata", mem_wdata, 32'h0);
    check("rst_i_rdata", i_rdata, 32'h0);
    check("rst_d_rdata", d_rdata, 32'h0);
    check("rst_strobes", {30'h0, mem_read, mem_write}, 32'h0);
    check("rst_acks", {29'h0, i_ack, d_ack, bus_err}, 32'h0);

    // Single instruction read, ready one cycle after grant
    i_addr = 32'h0000_0040; i_req = 1'b1;
    serve(0, 32'h0000_0040, 32'h0, 32'h1234_5678, 1);

    // Round-robin: data wins first tie, then instruction, then data again
    i_addr = 32'h200; i_req = 1'b1;
    d_addr = 32'h300; d_read = 1'b1;
    serve(1, 32'h300, 32'h0, 32'hAAAA_0001, 2);
    d_addr = 32'h304; d_read = 1'b1;
    serve(0, 32'h200, 32'h0, 32'hBBBB_0002, 1);
    i_addr = 32'h208; i_req = 1'b1;
    serve(1, 32'h304, 32'h0, 32'hAAAA_0003, 3);
    serve(0, 32'h208, 32'h0, 32'hBBBB_0004, 1);

    // Write, done after 4 dwell cycles
    d_addr = 32'h100; d_wdata = 32'hCAFE_F00D; d_write = 1'b1;
    serve(2, 32'h100, 32'hCAFE_F00D, 32'h0, 4);
    check("d_rdata_hold", d_rdata, 32'hAAAA_0003);

    // Read timeout, then a normal read
    d_addr = 32'h500; d_read = 1'b1;
    serve(1, 32'h500, 32'h0, 32'h0, 0);
    check("d_rdata_timeout", d_rdata, 32'h0);
    d_addr = 32'h504; d_read = 1'b1;
    serve(1, 32'h504, 32'h0, 32'h5566_7788, 2);
    check("i_rdata_hold", i_rdata, 32'hBBBB_0004);

    // Reset in the middle of a data read
    d_addr = 32'h900; d_read = 1'b1;
    @(posedge clk); #1;
    check("mid_mem_read", {31'h0, mem_read}, 32'h1);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0; d_read = 1'b0;
    check("mid_rst_strobe", {30'h0, mem_read, mem_write}, 32'h0);
    check("mid_rst_d_rdata", d_rdata, 32'h0);
    check("mid_rst_addr", mem_addr, 32'h0);
    repeat (2) begin
      check("mid_rst_noack", {30'h0, i_ack, d_ack}, 32'h0);
      @(posedge clk); #1;
    end
    i_addr = 32'h600; i_req = 1'b1;
    d_addr = 32'h700; d_read = 1'b1;
    serve(1, 32'h700, 32'h0, 32'h7777_0000, 1);
    serve(0, 32'h600, 32'h0, 32'h6666_0000, 1);

    // Simultaneous read and write: write performed
    d_addr = 32'h800; d_wdata = 32'h0BAD_C0DE; d_read = 1'b1; d_write = 1'b1;
    serve(2, 32'h800, 32'h0BAD_C0DE, 32'h0, 2);

    // Spurious ready/done while idle
    mem_read_ready = 1'b1; mem_write_done = 1'b1; mem_rdata = 32'hFFFF_FFFF;
    repeat (3) begin
      @(posedge clk); #1;
      check("idle_noack", {30'h0, i_ack, d_ack}, 32'h0);
      check("idle_strobes", {30'h0, mem_read, mem_write}, 32'h0);
    end
    mem_read_ready = 1'b0; mem_write_done = 1'b0;
    @(posedge clk); #1;
    check("idle_d_rdata", d_rdata, 32'h7777_0000);
    check("queue_empty", exp_q.size(), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
